// File: rtl/dcache_assoc_wb.sv
// dcache_assoc_wb: N-way write-back, write-allocate data cache with true-LRU and flush-on-halt
module dcache_assoc_wb #(
    parameter int          NSETS       = 8,
    parameter int          WAYS        = 2,
    parameter int          BLOCK_WORDS = 2,
    parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int WSEL = $clog2(BLOCK_WORDS);
    localparam int OB   = WSEL + 2;
    localparam int IB   = $clog2(NSETS);
    localparam int TB   = 32 - OB - IB;
    localparam int AW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, HITCNT, DONE} state_t;

    logic [TB-1:0]   tags  [NSETS][WAYS];
    logic [31:0]     data  [NSETS][WAYS][BLOCK_WORDS];
    logic            valid [NSETS][WAYS];
    logic            dirty [NSETS][WAYS];
    logic [AW-1:0]   age   [NSETS][WAYS];

    state_t          state;
    logic [WSEL-1:0] w;
    logic [AW-1:0]   vw, fw;
    logic [IB-1:0]   ridx, fs;
    logic [TB-1:0]   rtag;
    logic [31:0]     hitcount, prev_addr;
    logic            prev_hit, prev_ren, prev_wen;

    logic [IB-1:0]   idx;
    logic [TB-1:0]   tag;
    logic [WSEL-1:0] wsel;
    logic            hit_any, inv_any, hit, miss, new_req, fl_dirty, last_w, last_way, last_pair, flush_step;
    logic [AW-1:0]   hit_way, inv_way, lru_way, victim;

    // Address decode, tag lookup, victim choice and flush-scan bookkeeping
    always_comb begin
        idx     = dmemaddr[OB+IB-1:OB];
        tag     = dmemaddr[31:OB+IB];
        wsel    = dmemaddr[OB-1:2];
        hit_any = 1'b0;
        inv_any = 1'b0;
        hit_way = '0;
        inv_way = '0;
        lru_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid[idx][i] && tags[idx][i] == tag) begin
                hit_any = 1'b1;
                hit_way = AW'(i);
            end
            if (!valid[idx][i]) begin
                inv_any = 1'b1;
                inv_way = AW'(i);
            end
            if (age[idx][i] == AW'(WAYS - 1))
                lru_way = AW'(i);
        end
        victim     = inv_any ? inv_way : lru_way;
        hit        = state == IDLE && !halt && (dmemREN || dmemWEN) && hit_any;
        miss       = state == IDLE && !halt && (dmemREN || dmemWEN) && !hit_any;
        new_req    = !(prev_hit && prev_addr == dmemaddr && prev_ren == dmemREN && prev_wen == dmemWEN);
        fl_dirty   = valid[fs][fw] && dirty[fs][fw];
        last_w     = w == WSEL'(BLOCK_WORDS - 1);
        last_way   = fw == AW'(WAYS - 1);
        last_pair  = last_way && fs == IB'(NSETS - 1);
        flush_step = fl_dirty ? !dwait && last_w : 1'b1;
    end

    // Datapath and memory-side outputs, all driven from current state
    always_comb begin
        dhit     = hit;
        dmemload = hit ? data[idx][hit_way][wsel] : '0;
        flushed  = state == DONE;
        dREN     = state == FETCH;
        dWEN     = state == WB || state == HITCNT || (state == FLUSH && fl_dirty);
        daddr    = state == WB                 ? {tags[ridx][vw], ridx, w, 2'b00} :
                   state == FETCH              ? {rtag, ridx, w, 2'b00} :
                   state == FLUSH && fl_dirty  ? {tags[fs][fw], fs, w, 2'b00} :
                   state == HITCNT             ? HITCNT_ADDR : '0;
        dstore   = state == WB                 ? data[ridx][vw][w] :
                   state == FLUSH && fl_dirty  ? data[fs][fw][w] :
                   state == HITCNT             ? hitcount : '0;
    end

    // Controller: hit service with LRU update, miss write-back/fill, flush and hit-count report
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            w         <= '0;
            vw        <= '0;
            fw        <= '0;
            fs        <= '0;
            ridx      <= '0;
            rtag      <= '0;
            hitcount  <= '0;
            prev_addr <= '0;
            prev_hit  <= 1'b0;
            prev_ren  <= 1'b0;
            prev_wen  <= 1'b0;
            for (int s = 0; s < NSETS; s++)
                for (int k = 0; k < WAYS; k++) begin
                    valid[s][k] <= 1'b0;
                    dirty[s][k] <= 1'b0;
                    tags[s][k]  <= '0;
                    age[s][k]   <= AW'(k);
                    for (int b = 0; b < BLOCK_WORDS; b++)
                        data[s][k][b] <= '0;
                end
        end else begin
            prev_hit  <= hit;
            prev_addr <= dmemaddr;
            prev_ren  <= dmemREN;
            prev_wen  <= dmemWEN;
            case (state)
                IDLE: begin
                    if (halt) begin
                        state <= FLUSH;
                        fs    <= '0;
                        fw    <= '0;
                        w     <= '0;
                    end else if (hit) begin
                        if (new_req)
                            hitcount <= hitcount + 1;
                        if (dmemWEN) begin
                            data[idx][hit_way][wsel] <= dmemstore;
                            dirty[idx][hit_way]      <= 1'b1;
                        end
                        for (int i = 0; i < WAYS; i++)
                            if (AW'(i) == hit_way)
                                age[idx][i] <= '0;
                            else if (age[idx][i] < age[idx][hit_way])
                                age[idx][i] <= age[idx][i] + 1'b1;
                    end else if (miss) begin
                        ridx              <= idx;
                        rtag              <= tag;
                        vw                <= victim;
                        w                 <= '0;
                        valid[idx][victim] <= 1'b0;
                        state             <= valid[idx][victim] && dirty[idx][victim] ? WB : FETCH;
                    end
                end
                WB: begin
                    if (!dwait) begin
                        w <= w + 1'b1;
                        if (last_w)
                            state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!dwait) begin
                        data[ridx][vw][w] <= dload;
                        w                 <= w + 1'b1;
                        if (last_w) begin
                            valid[ridx][vw] <= 1'b1;
                            dirty[ridx][vw] <= 1'b0;
                            tags[ridx][vw]  <= rtag;
                            state           <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (fl_dirty && !dwait) begin
                        w <= w + 1'b1;
                        if (last_w)
                            dirty[fs][fw] <= 1'b0;
                    end
                    if (flush_step) begin
                        fw <= last_way ? '0 : fw + 1'b1;
                        fs <= last_way ? fs + 1'b1 : fs;
                        if (last_pair)
                            state <= HITCNT;
                    end
                end
                HITCNT: begin
                    if (!dwait)
                        state <= DONE;
                end
                default: state <= DONE;
            endcase
        end
    end
endmodule
